// File: rtl/alu_ctrl.sv
// Two-requester sequencer sharing one 16-bit ripple ALU; single-cycle logic/arith ops
// and a 16-cycle shift-add multiply, with a tagged valid/ready response channel.

module alu (
    input  logic [15:0] i0,
    input  logic [15:0] i1,
    input  logic [1:0]  op,
    output logic [15:0] o,
    output logic        cout
);
    logic [16:0] carry;
    logic [15:0] sum;
    logic        sub;

    assign sub = (op == 2'b01);

    // Subtract as a + ~b + 1, so carry out of 1 means no borrow.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = sub;
        for (int unsigned i = 0; i < 16; i++) begin
            sum[i]     = i0[i] ^ (i1[i] ^ sub) ^ carry[i];
            carry[i+1] = (i0[i] & (i1[i] ^ sub)) | (carry[i] & (i0[i] ^ (i1[i] ^ sub)));
        end
    end

    always_comb begin
        o    = '0;
        cout = 1'b0;
        case (op)
            2'b00, 2'b01: begin
                o    = sum;
                cout = carry[16];
            end
            2'b10:   o = i0 & i1;
            default: o = i0 | i1;
        endcase
    end
endmodule

module alu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_cmd,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_cmd,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_cout,
    output logic        rsp_err,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    logic        rr;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [2:0]  cmd_q;
    logic        id_q;
    logic [15:0] acc;
    logic [3:0]  cnt;
    logic        sticky;

    logic        gnt0;
    logic        gnt1;
    logic [2:0]  gnt_cmd;

    logic [15:0] alu_i0;
    logic [15:0] alu_i1;
    logic [1:0]  alu_op;
    logic [15:0] alu_o;
    logic        alu_cout;

    // Grant depends only on state, rr and the two valids; rsp_ready never feeds it.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state == IDLE) begin
            gnt0 = req0_valid & (~req1_valid | ~rr);
            gnt1 = req1_valid & (~req0_valid |  rr);
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign gnt_cmd    = gnt1 ? req1_cmd : req0_cmd;
    assign busy       = (state != IDLE);

    always_comb begin
        if (state == MUL) begin
            alu_i0 = acc;
            alu_i1 = b_q[0] ? a_q : '0;
            alu_op = 2'b00;
        end else begin
            alu_i0 = a_q;
            alu_i1 = b_q;
            alu_op = cmd_q[1:0];
        end
    end

    alu u_alu (
        .i0   (alu_i0),
        .i1   (alu_i1),
        .op   (alu_op),
        .o    (alu_o),
        .cout (alu_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cmd_q     <= '0;
            id_q      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        id_q   <= gnt1;
                        a_q    <= gnt1 ? req1_a : req0_a;
                        b_q    <= gnt1 ? req1_b : req0_b;
                        cmd_q  <= gnt_cmd;
                        acc    <= '0;
                        cnt    <= '0;
                        sticky <= 1'b0;
                        state  <= (gnt_cmd == 3'b100) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    if (cmd_q > 3'b100) begin
                        rsp_data <= '0;
                        rsp_cout <= 1'b0;
                        rsp_err  <= 1'b1;
                    end else begin
                        rsp_data <= alu_o;
                        rsp_cout <= alu_cout;
                        rsp_err  <= 1'b0;
                    end
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                MUL: begin
                    acc    <= alu_o;
                    sticky <= sticky | alu_cout;
                    a_q    <= a_q << 1;
                    b_q    <= b_q >> 1;
                    cnt    <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        rsp_data  <= alu_o;
                        rsp_cout  <= sticky | alu_cout;
                        rsp_err   <= 1'b0;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr        <= ~rsp_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: stimulus pushes expected responses, a monitor
// pops and compares them on every response handshake.

module tb_alu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_cmd = '0, req1_cmd = '0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout, rsp_err, busy;
    logic [15:0] rsp_data;

    typedef struct packed {
        logic        id;
        logic [15:0] data;
        logic        cout;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [2:0] C_ADD = 3'b000, C_SUB = 3'b001, C_AND = 3'b010,
                           C_OR  = 3'b011, C_MUL = 3'b100, C_BAD = 3'b110;

    alu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_cmd   (req0_cmd),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_cmd   (req1_cmd),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_cout   (rsp_cout),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // rsp_ready only changes just after a rising edge, so the falling-edge view is the handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                rsp_t e;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id",   rsp_id,   e.id);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_cout", rsp_cout, e.cout);
                    chk("rsp_err",  rsp_err,  e.err);
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string name);
        chk({name, "_req0_ready"}, req0_ready, 0);
        chk({name, "_req1_ready"}, req1_ready, 0);
        chk({name, "_rsp_valid"},  rsp_valid,  0);
        chk({name, "_busy"},       busy,       0);
        chk({name, "_rsp_data"},   rsp_data,   0);
        chk({name, "_rsp_id"},     rsp_id,     0);
        chk({name, "_rsp_cout"},   rsp_cout,   0);
        chk({name, "_rsp_err"},    rsp_err,    0);
    endtask

    // Called just after a rising edge with rsp_ready high.
    task automatic do_op(input logic id, input logic [2:0] cmd, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] ed, input logic ec,
                         input logic ee, input int lat, input string name);
        int   n;
        rsp_t e;
        if (id) begin
            req1_valid = 1'b1; req1_cmd = cmd; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_cmd = cmd; req0_a = a; req0_b = b;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) begin
            chk({name, "_grant_timeout"}, 32'd1, 32'd0);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        e = {id, ed, ec, ee};
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            chk({name, "_busy"}, busy, 1);
            @(posedge clk); #1; n++;
        end
        chk({name, "_latency"}, n, lat);
        n = 0;
        while (rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_consumed"}, rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          grants;
        rsp_t        e;
        logic [15:0] snap_data;
        logic        snap_id, snap_err;

        // Reset with both requesters asserting valid.
        req0_valid = 1'b1; req0_cmd = C_ADD; req0_a = 16'd5; req0_b = 16'd7;
        req1_valid = 1'b1; req1_cmd = C_ADD; req1_a = 16'd9; req1_b = 16'd9;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk("first_grant_r0", req0_ready, 1);
        chk("first_grant_r1", req1_ready, 0);
        req1_valid = 1'b0;
        do_op(1'b0, C_ADD, 16'd5, 16'd7, 16'd12, 1'b0, 1'b0, 1, "add_r0");

        do_op(1'b1, C_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1, "add_wrap");
        do_op(1'b1, C_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1, "sub_borrow");
        do_op(1'b1, C_SUB, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1, "sub_noborrow");
        do_op(1'b1, C_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1, "and");
        do_op(1'b1, C_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b0, 1, "or");
        do_op(1'b0, C_MUL, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 16, "mul_small");
        // Shifted-out multiplicand bits never reach the adder, so no carry here.
        do_op(1'b1, C_MUL, 16'h8000, 16'h0003, 16'h8000, 1'b0, 1'b0, 16, "mul_8000x3");
        do_op(1'b1, C_MUL, 16'hFFFF, 16'h0003, 16'hFFFD, 1'b1, 1'b0, 16, "mul_sticky");

        // Round-robin: last response came from requester 1, so requester 0 goes first.
        req0_valid = 1'b1; req0_cmd = C_ADD; req0_a = 16'h0001; req0_b = 16'h0002;
        req1_valid = 1'b1; req1_cmd = C_ADD; req1_a = 16'h0010; req1_b = 16'h0020;
        #1;
        grants = 0;
        n = 0;
        while (grants < 4 && n < 100) begin
            if (req0_ready || req1_ready) begin
                chk("rr_exclusive", req0_ready & req1_ready, 0);
                chk("rr_order", req1_ready, grants % 2);
                if (req1_ready) e = {1'b1, 16'h0030, 1'b0, 1'b0};
                else            e = {1'b0, 16'h0003, 1'b0, 1'b0};
                exp_q.push_back(e);
                grants++;
            end
            @(posedge clk); #1; n++;
        end
        chk("rr_grants", grants, 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (busy && n < 50) begin @(posedge clk); #1; n++; end
        chk("rr_idle", busy, 0);

        // Backpressure with an illegal command while requester 1 waits.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_cmd = C_BAD; req0_a = 16'h1234; req0_b = 16'h5678;
        req1_valid = 1'b1; req1_cmd = C_ADD; req1_a = 16'h0003; req1_b = 16'h0004;
        #1;
        chk("bp_grant_r0", req0_ready, 1);
        chk("bp_no_r1", req1_ready, 0);
        e = {1'b0, 16'h0000, 1'b0, 1'b1};
        exp_q.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_err", rsp_err, 1);
        chk("bp_data", rsp_data, 16'h0000);
        snap_data = rsp_data; snap_id = rsp_id; snap_err = rsp_err;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_data", rsp_data, snap_data);
            chk("bp_hold_id", rsp_id, snap_id);
            chk("bp_hold_err", rsp_err, snap_err);
            chk("bp_hold_r0", req0_ready, 0);
            chk("bp_hold_r1", req1_ready, 0);
        end
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
        n = 0;
        while (!req1_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp_r1_granted", req1_ready, 1);
        e = {1'b1, 16'h0007, 1'b0, 1'b0};
        exp_q.push_back(e);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        n = 0;
        while (busy && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_idle", busy, 0);

        // Reset in the middle of a multiply: no response, everything back to reset values.
        req0_valid = 1'b1; req0_cmd = C_MUL; req0_a = 16'h0012; req0_b = 16'h0034;
        #1;
        chk("rstmul_grant", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("rstmul_busy_before", busy, 1);
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rstmul");
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(1'b0, C_MUL, 16'h0007, 16'h0009, 16'h003F, 1'b0, 1'b0, 16, "mul_after_rst");

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
